// File: rtl/mmio_timer_array.sv
// ---------------------------------------------------------------------------
// mmio_timer_array
// Multi-channel up-counting timer on the CPU MMIO bus. Each channel has an
// 8-bit prescaler, a CNT_WIDTH-bit counter compared against a terminal
// count, one-shot or periodic mode, a sticky done flag and a maskable IRQ.
// Each channel occupies 16 bytes: CTRL, STATUS, TARGET, CURRENT.
//
// Ports:
//   sys_clk          clock, all state on the rising edge
//   rst_n            synchronous active-low reset
//   mmio_read        read request
//   mmio_write       write request
//   mmio_addr        byte address (bits [1:0] ignored)
//   mmio_write_data  write data
//   mmio_work        request addresses this block (combinational)
//   mmio_done        handshake completion, high in the second cycle
//   mmio_read_data   read data (combinational, 0 outside the window)
//   irq              per-channel interrupt, done & irq_en
//   irq_any          OR of irq
// ---------------------------------------------------------------------------
module mmio_timer_array #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0280,
  parameter int          CHANNELS  = 2,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                mmio_read,
  input  logic                mmio_write,
  input  logic [31:0]         mmio_addr,
  input  logic [31:0]         mmio_write_data,
  output logic                mmio_work,
  output logic                mmio_done,
  output logic [31:0]         mmio_read_data,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  localparam int CH_LOG  = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int CH_BITS = (CH_LOG > 0) ? CH_LOG : 1;
  localparam int WIN_LSB = 4 + CH_LOG;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TARGET  = 2'd2;
  localparam logic [1:0] REG_CURRENT = 2'd3;

  logic               in_window;
  logic               wr_commit;
  logic               mmio_done_q;
  logic               mmio_done_d;
  logic [CH_BITS-1:0] ch_sel;
  logic [1:0]         reg_sel;
  logic [31:0]        reg_rd [CHANNELS][4];
  logic               unused_bits;

  // The window is aligned to its own size, so a compare of the upper
  // address bits is an exact range check.
  assign in_window = (mmio_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign mmio_work = in_window & (mmio_read | mmio_write);
  assign reg_sel   = mmio_addr[3:2];

  generate
    if (CHANNELS > 1) begin : g_ch_sel
      assign ch_sel = mmio_addr[4 +: CH_BITS];
    end else begin : g_ch_sel_single
      assign ch_sel = '0;
    end
  endgenerate

  // Writes take effect only on the edge closing the first handshake cycle,
  // so a request held through the second cycle is not applied twice.
  assign wr_commit   = mmio_write & mmio_work & ~mmio_done_q;
  assign mmio_done_d = mmio_work & ~mmio_done_q;
  assign mmio_done   = mmio_done_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      mmio_done_q <= 1'b0;
    end else begin
      mmio_done_q <= mmio_done_d;
    end
  end

  always_comb begin
    mmio_read_data = '0;
    if (in_window && mmio_read) begin
      mmio_read_data = reg_rd[ch_sel][reg_sel];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic                 enable_q, enable_d;
      logic                 periodic_q, periodic_d;
      logic                 irq_en_q, irq_en_d;
      logic                 done_q, done_d;
      logic [7:0]           prescale_q, prescale_d;
      logic [7:0]           pcnt_q, pcnt_d;
      logic [CNT_WIDTH-1:0] target_q, target_d;
      logic [CNT_WIDTH-1:0] count_q, count_d;
      logic                 wr_sel;
      logic                 tick;
      logic                 hit;

      assign wr_sel = wr_commit && (ch_sel == CH_BITS'(gi));
      assign tick   = enable_q && (pcnt_q == prescale_q);
      // Terminal tick: compares against the TARGET held before any
      // same-edge write.
      assign hit    = tick && (count_q == target_q);

      always_comb begin
        enable_d   = enable_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        target_d   = target_q;
        count_d    = count_q;

        if (enable_q) begin
          pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end

        if (tick) begin
          if (hit) begin
            if (periodic_q) begin
              count_d = '0;
            end else begin
              enable_d = 1'b0;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end

        // Bus writes are applied after the counter update so that a
        // same-edge write overrides the hardware result.
        if (wr_sel) begin
          case (reg_sel)
            REG_CTRL: begin
              enable_d   = mmio_write_data[0];
              periodic_d = mmio_write_data[1];
              irq_en_d   = mmio_write_data[2];
              prescale_d = mmio_write_data[15:8];
              if (!enable_q && mmio_write_data[0]) begin
                pcnt_d = 8'd0;
              end
            end
            REG_STATUS: begin
              if (mmio_write_data[0]) begin
                done_d = 1'b0;
              end
            end
            REG_TARGET: begin
              target_d = mmio_write_data[CNT_WIDTH-1:0];
            end
            default: begin
              count_d = mmio_write_data[CNT_WIDTH-1:0];
              pcnt_d  = 8'd0;
            end
          endcase
        end

        // A hardware set beats a software clear on the same edge.
        if (hit) begin
          done_d = 1'b1;
        end
      end

      always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
          enable_q   <= 1'b0;
          periodic_q <= 1'b0;
          irq_en_q   <= 1'b0;
          done_q     <= 1'b0;
          prescale_q <= 8'd0;
          pcnt_q     <= 8'd0;
          target_q   <= '0;
          count_q    <= '0;
        end else begin
          enable_q   <= enable_d;
          periodic_q <= periodic_d;
          irq_en_q   <= irq_en_d;
          done_q     <= done_d;
          prescale_q <= prescale_d;
          pcnt_q     <= pcnt_d;
          target_q   <= target_d;
          count_q    <= count_d;
        end
      end

      assign reg_rd[gi][0] = {16'd0, prescale_q, 5'd0, irq_en_q, periodic_q, enable_q};
      assign reg_rd[gi][1] = {30'd0, enable_q, done_q};
      assign reg_rd[gi][2] = 32'(target_q);
      assign reg_rd[gi][3] = 32'(count_q);
      assign irq[gi]       = done_q & irq_en_q;
    end
  endgenerate

  assign irq_any = |irq;

  // Address byte-lane bits and write-data bits beyond the register
  // fields carry no meaning for this block.
  assign unused_bits = &{1'b0, mmio_addr[1:0], mmio_write_data};

endmodule

// File: tb/tb_mmio_timer_array.sv
module tb_mmio_timer_array;

  localparam logic [31:0] BASE = 32'hFFFF0280;
  localparam int NCH  = 2;
  localparam int CW   = 8;
  localparam int CMAX = 256;   // counter modulus for CW = 8

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mmio_read = 1'b0;
  logic              mmio_write = 1'b0;
  logic [31:0]       mmio_addr = 32'd0;
  logic [31:0]       mmio_write_data = 32'd0;
  logic              mmio_work;
  logic              mmio_done;
  logic [31:0]       mmio_read_data;
  logic [NCH-1:0]    irq;
  logic              irq_any;

  always #5 sys_clk = ~sys_clk;

  mmio_timer_array #(
    .BASE_ADDR(BASE),
    .CHANNELS(NCH),
    .CNT_WIDTH(CW)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .mmio_read(mmio_read),
    .mmio_write(mmio_write),
    .mmio_addr(mmio_addr),
    .mmio_write_data(mmio_write_data),
    .mmio_work(mmio_work),
    .mmio_done(mmio_done),
    .mmio_read_data(mmio_read_data),
    .irq(irq),
    .irq_any(irq_any)
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  int m_en[NCH], m_per[NCH], m_ie[NCH], m_p[NCH];
  int m_t[NCH], m_c[NCH], m_pc[NCH], m_done[NCH];
  bit m_hs;

  function automatic bit in_win(logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 16 * NCH);
  endfunction

  function automatic int win_ch(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 16);
  endfunction

  function automatic int win_reg(logic [31:0] a);
    return int'(((longint'(a) - longint'(BASE)) % 16) / 4);
  endfunction

  function automatic logic [31:0] model_read(int ch, int r);
    int v;
    case (r)
      0: v = m_p[ch] * 256 + m_ie[ch] * 4 + m_per[ch] * 2 + m_en[ch];
      1: v = m_en[ch] * 2 + m_done[ch];
      2: v = m_t[ch];
      default: v = m_c[ch];
    endcase
    return 32'(v);
  endfunction

  always @(posedge sys_clk) begin : model
    bit commit, term, old_en, req;
    int wd;
    if (!rst_n) begin
      m_hs = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_p[c] = 0;
        m_t[c] = 0; m_c[c] = 0; m_pc[c] = 0; m_done[c] = 0;
      end
    end else begin
      req    = (mmio_read || mmio_write) && in_win(mmio_addr);
      commit = mmio_write && in_win(mmio_addr) && !m_hs;
      wd     = int'(mmio_write_data);
      for (int c = 0; c < NCH; c++) begin
        old_en = (m_en[c] != 0);
        term   = 1'b0;
        if (old_en) begin
          if (m_pc[c] == m_p[c]) begin
            m_pc[c] = 0;
            if (m_c[c] == m_t[c]) begin
              term = 1'b1;
              if (m_per[c] != 0) m_c[c] = 0;
              else m_en[c] = 0;
            end else begin
              m_c[c] = (m_c[c] + 1) % CMAX;
            end
          end else begin
            m_pc[c] = (m_pc[c] + 1) % 256;
          end
        end
        if (commit && win_ch(mmio_addr) == c) begin
          case (win_reg(mmio_addr))
            0: begin
              if (!old_en && (wd & 1) != 0) m_pc[c] = 0;
              m_en[c]  = wd & 1;
              m_per[c] = (wd >> 1) & 1;
              m_ie[c]  = (wd >> 2) & 1;
              m_p[c]   = (wd >> 8) & 255;
            end
            1: if ((wd & 1) != 0) m_done[c] = 0;
            2: m_t[c] = wd & (CMAX - 1);
            default: begin
              m_c[c]  = wd & (CMAX - 1);
              m_pc[c] = 0;
            end
          endcase
        end
        if (term) m_done[c] = 1;
      end
      m_hs = req && !m_hs;
    end
  end

  // ---------------- literal-expectation mailbox ----------------
  string       lit_name [256];
  logic [31:0] lit_act  [256];
  logic [31:0] lit_exp  [256];
  int          lit_wr = 0;
  int          lit_rd = 0;

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (lit_wr < 256) begin
      lit_name[lit_wr] = nm;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr++;
    end
  endtask

  // ---------------- compare process ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge sys_clk) begin : compare
    bit          exp_work;
    logic [31:0] exp_irq;
    exp_work = (mmio_read || mmio_write) && in_win(mmio_addr);
    exp_irq  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_done[c] != 0 && m_ie[c] != 0) exp_irq[c] = 1'b1;
    end
    chk("mmio_work", 32'(mmio_work), 32'(exp_work));
    chk("mmio_done", 32'(mmio_done), 32'(m_hs));
    chk("irq", 32'(irq), exp_irq);
    chk("irq_any", 32'(irq_any), 32'(exp_irq != 0));
    if (mmio_read && exp_work) begin
      chk("read_data", mmio_read_data, model_read(win_ch(mmio_addr), win_reg(mmio_addr)));
    end
    while (lit_rd < lit_wr) begin
      chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  // ---------------- bus tasks ----------------
  function automatic logic [31:0] ra(int ch, int r);
    return BASE + 32'(ch * 16 + r * 4);
  endfunction

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n;
    @(posedge sys_clk); #1;
    mmio_read = !wr; mmio_write = wr; mmio_addr = addr; mmio_write_data = wd;
    @(negedge sys_clk);
    rd = mmio_read_data;
    n = 0;
    while (!mmio_done && n < 4) begin
      @(negedge sys_clk);
      n++;
    end
    if (!mmio_done) post("handshake_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
    mmio_read = 1'b0; mmio_write = 1'b0;
  endtask

  task automatic wr_reg(input int ch, input int r, input logic [31:0] wd);
    logic [31:0] d;
    access(1'b1, ra(ch, r), wd, d);
  endtask

  task automatic rd_lit(input string nm, input int ch, input int r, input logic [31:0] exp);
    logic [31:0] d;
    access(1'b0, ra(ch, r), 32'd0, d);
    post(nm, d, exp);
  endtask

  task automatic access_oow(input bit wr, input logic [31:0] addr);
    @(posedge sys_clk); #1;
    mmio_read = !wr; mmio_write = wr; mmio_addr = addr; mmio_write_data = $urandom;
    @(negedge sys_clk);
    post("oow_work", 32'(mmio_work), 32'd0);
    if (!wr) post("oow_data", mmio_read_data, 32'd0);
    @(posedge sys_clk); #1;
    mmio_read = 1'b0; mmio_write = 1'b0;
  endtask

  task automatic wait_irq(input int ch, input int maxc, output int when);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!irq[ch] && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
    if (!irq[ch]) post("irq_wait_timeout", 32'd0, 32'd1);
    when = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int r1, r2, n;
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    post("reset_irq", 32'(irq), 32'd0);
    post("reset_done", 32'(mmio_done), 32'd0);
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) rd_lit("reset_reg", c, r, 32'd0);

    // Channel 0 one-shot, T=4, P=0: done/irq 5 edges after the commit.
    wr_reg(0, 2, 32'd4);
    wr_reg(0, 0, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      post("oneshot_irq_timing", 32'(irq[0]), (k == 5) ? 32'd1 : 32'd0);
    end
    rd_lit("oneshot_current", 0, 3, 32'd4);
    rd_lit("oneshot_ctrl", 0, 0, 32'h4);
    rd_lit("oneshot_status", 0, 1, 32'h1);

    // Channel 1 periodic, T=2, P=3: period 12 cycles.
    wr_reg(1, 2, 32'd2);
    wr_reg(1, 0, 32'h0307);
    wait_irq(1, 40, r1);
    wr_reg(1, 1, 32'h1);
    wait_irq(1, 40, r2);
    post("periodic_period", 32'(r2 - r1), 32'd12);
    wr_reg(1, 1, 32'h1);
    n = 0;
    while (cyc < r2 + 10 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    post("pre_collide_irq", 32'(irq[1]), 32'd0);
    wr_reg(1, 1, 32'h1);        // commits on the terminal edge
    post("clear_vs_set", 32'(irq[1]), 32'd1);
    wr_reg(1, 0, 32'h0);
    wr_reg(1, 1, 32'h1);

    // Counter wrap at 8 bits, one-shot from C > T.
    wr_reg(0, 0, 32'h0);
    wr_reg(0, 1, 32'h1);
    wr_reg(0, 3, 32'hFE);
    wr_reg(0, 2, 32'h01);
    wr_reg(0, 0, 32'h1);
    repeat (6) @(negedge sys_clk);
    rd_lit("wrap_current", 0, 3, 32'h01);
    rd_lit("wrap_status", 0, 1, 32'h1);
    wr_reg(0, 2, 32'h1FF);
    rd_lit("target_trunc", 0, 2, 32'hFF);

    // Held CURRENT write on a running counter loads once.
    wr_reg(0, 2, 32'd200);
    wr_reg(0, 0, 32'h3);
    wr_reg(0, 3, 32'd10);
    rd_lit("single_load", 0, 3, 32'd12);

    access_oow(1'b0, BASE + 32'd32);
    access_oow(1'b0, BASE - 32'd4);
    access_oow(1'b1, BASE + 32'd36);

    // irq masking with done already set on channel 0.
    wr_reg(0, 0, 32'h0);
    post("masked_irq", 32'(irq), 32'd0);
    post("masked_irq_any", 32'(irq_any), 32'd0);
    wr_reg(0, 0, 32'h4);
    post("unmasked_irq", 32'(irq), 32'd1);
    post("unmasked_irq_any", 32'(irq_any), 32'd1);

    // Reset while a handshake is in its second cycle.
    @(posedge sys_clk); #1;
    mmio_write = 1'b1; mmio_addr = ra(1, 2); mmio_write_data = 32'h33;
    @(posedge sys_clk); #1;
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    mmio_write = 1'b0;
    post("reset_mid_done", 32'(mmio_done), 32'd0);
    rst_n = 1'b1;
    rd_lit("after_reset_target", 1, 2, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int ch, r;
      bit wr;
      logic [31:0] wd;
      ch = $urandom_range(0, NCH - 1);
      r  = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      case (r)
        0: wd = ($urandom & 32'hFFFF00F8) | (32'($urandom_range(0, 3)) << 8)
                | 32'($urandom_range(0, 7));
        1: wd = $urandom;
        2: wd = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
        default: wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 9) == 0) begin
        access_oow(wr, ($urandom_range(0, 1) != 0) ? BASE + 32'd32 + 32'($urandom_range(0, 255))
                                                   : BASE - 32'd1 - 32'($urandom_range(0, 255)));
      end else begin
        access(wr, ra(ch, r) + 32'($urandom_range(0, 3)), wd, d);
      end
      repeat ($urandom_range(0, 4)) @(posedge sys_clk);
    end

    repeat (3) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
